// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the multi-channel interrupt controller:
// register map, channel limit and vector width.
package int_ctrl_pkg;

    localparam int MAX_IRQ = 8;
    localparam int VEC_W   = 3;

    typedef enum logic [1:0] {
        REG_DISABLE = 2'd0,
        REG_MODE    = 2'd1,
        REG_PENDING = 2'd2,
        REG_VECTOR  = 2'd3
    } reg_addr_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: vec is the lowest set request bit,
// zero when nothing is requested.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    output logic [VEC_W-1:0] vec,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last to write vec.
    always_comb begin
        vec = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec = VEC_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/int_ctrl_multi.sv
// Multi-channel interrupt controller with per-channel mask, level/edge mode,
// W1C pending register and priority vector. Define INT_CTRL_SYNC_EN to add a
// 2-flop input synchroniser on every irq_n line.
module int_ctrl_multi
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RDY,
    input  logic               re,
    input  logic               we,
    input  logic               CECG_n,
    input  logic [1:0]         addr,
    input  logic [7:0]         dIn,
    output logic [7:0]         dOut,
    input  logic [NUM_IRQ-1:0] irq_n,
    output logic [NUM_IRQ-1:0] irq,
    output logic               irq_any,
    output logic [VEC_W-1:0]   irq_vec
);

    logic [NUM_IRQ-1:0] mask_reg, mask_next;
    logic [NUM_IRQ-1:0] mode_reg, mode_next;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] prev_reg;
    logic [NUM_IRQ-1:0] req_s;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] wdata;
    logic               wr_en, rd_en;
    logic               wr_disable, wr_mode, wr_pending;
    logic               unused_din;

    assign wr_en      = RDY & ~CECG_n & we;
    assign rd_en      = ~CECG_n & re;
    assign wr_disable = wr_en & (reg_addr_e'(addr) == REG_DISABLE);
    assign wr_mode    = wr_en & (reg_addr_e'(addr) == REG_MODE);
    assign wr_pending = wr_en & (reg_addr_e'(addr) == REG_PENDING);
    assign wdata      = dIn[NUM_IRQ-1:0];
    assign unused_din = ^dIn;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg, sync2_reg;

    // Flops hold the active-high request, so reset to 0 means "inactive".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= ~irq_n;
            sync2_reg <= sync1_reg;
        end
    end

    assign req_s = sync2_reg;
`else
    assign req_s = ~irq_n;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            assign edge_det[gi]  = req_s[gi] & ~prev_reg[gi];
            assign mask_next[gi] = wr_disable ? wdata[gi] : mask_reg[gi];
            assign mode_next[gi] = wr_mode ? wdata[gi] : mode_reg[gi];
            // Set beats clear; masking with mode_next keeps level channels at 0.
            assign pending_next[gi] = mode_next[gi] &
                ((mode_reg[gi] & edge_det[gi]) |
                 (pending_reg[gi] & ~(wr_pending & wdata[gi])));
            assign irq[gi] = (mode_reg[gi] ? pending_reg[gi] : req_s[gi]) & ~mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg    <= '0;
            mode_reg    <= '0;
            pending_reg <= '0;
            prev_reg    <= '0;
        end else begin
            mask_reg    <= mask_next;
            mode_reg    <= mode_next;
            pending_reg <= pending_next;
            prev_reg    <= req_s;
        end
    end

    int_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio (
        .req (irq),
        .vec (irq_vec),
        .any (irq_any)
    );

    always_comb begin
        dOut = '0;
        if (rd_en) begin
            case (reg_addr_e'(addr))
                REG_DISABLE: dOut = 8'(mask_reg);
                REG_MODE:    dOut = 8'(mode_reg);
                REG_PENDING: dOut = 8'(pending_reg);
                REG_VECTOR:  dOut = {irq_any, 4'b0000, irq_vec};
                default:     dOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Bench for int_ctrl_multi: directed scenarios plus random traffic checked
// against a behavioural register-level model.
module tb_int_ctrl_multi;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset, RDY, re, we, CECG_n;
    logic [1:0]   addr;
    logic [7:0]   dIn;
    logic [7:0]   dOut;
    logic [N-1:0] irq_n;
    logic [N-1:0] irq;
    logic         irq_any;
    logic [2:0]   irq_vec;

    always #5 clk = ~clk;

    int_ctrl_multi #(.NUM_IRQ(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .RDY     (RDY),
        .re      (re),
        .we      (we),
        .CECG_n  (CECG_n),
        .addr    (addr),
        .dIn     (dIn),
        .dOut    (dOut),
        .irq_n   (irq_n),
        .irq     (irq),
        .irq_any (irq_any),
        .irq_vec (irq_vec)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    // Model state: register contents, previous sample, synchroniser history.
    bit m_dis [N];
    bit m_mode[N];
    bit m_pend[N];
    bit m_prev[N];
    bit m_h0  [N];
    bit m_h1  [N];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit model_s(input int i);
`ifdef INT_CTRL_SYNC_EN
        return m_h1[i];
`else
        return !irq_n[i];
`endif
    endfunction

    task automatic check_model();
        logic [7:0] e_irq, e_dout;
        int         e_vec;
        bit         e_any;
        e_irq = 0; e_vec = 0; e_any = 0;
        for (int i = 0; i < N; i++) begin
            e_irq[i] = (m_mode[i] ? m_pend[i] : model_s(i)) && !m_dis[i];
            if (e_irq[i] && !e_any) begin
                e_vec = i;
                e_any = 1;
            end
        end
        e_dout = 0;
        if (!CECG_n && re) begin
            for (int i = 0; i < N; i++) begin
                case (addr)
                    2'd0: e_dout[i] = m_dis[i];
                    2'd1: e_dout[i] = m_mode[i];
                    2'd2: e_dout[i] = m_pend[i];
                    default: ;
                endcase
            end
            if (addr == 2'd3) e_dout = (e_any ? 8'h80 : 8'h00) | 8'(e_vec);
        end
        chk("irq", 8'(irq), e_irq);
        chk("irq_any", 8'(irq_any), 8'(e_any));
        chk("irq_vec", 8'(irq_vec), 8'(e_vec));
        chk("dOut", dOut, e_dout);
    endtask

    task automatic model_update();
        bit s[N];
        bit wr;
        for (int i = 0; i < N; i++) s[i] = model_s(i);
        wr = RDY && !CECG_n && we;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_dis[i] = 0; m_mode[i] = 0; m_pend[i] = 0;
                m_prev[i] = 0; m_h0[i] = 0; m_h1[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit edge_seen = s[i] && !m_prev[i];
                if (m_mode[i] && edge_seen) m_pend[i] = 1;
                else if (wr && addr == 2'd2 && dIn[i]) m_pend[i] = 0;
                if (wr && addr == 2'd0) m_dis[i] = dIn[i];
                if (wr && addr == 2'd1) m_mode[i] = dIn[i];
                if (!m_mode[i]) m_pend[i] = 0;
                m_prev[i] = s[i];
                m_h1[i]   = m_h0[i];
                m_h0[i]   = !irq_n[i];
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        $display("cyc %0d rst=%b wr=%b rd=%b addr=%0d din=%h irq_n=%b -> irq=%b vec=%0d dout=%h",
                 cyc, reset, RDY & ~CECG_n & we, ~CECG_n & re, addr, dIn, irq_n, irq, irq_vec, dOut);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic set_bus(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        we = w; re = r; addr = a; dIn = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_dis[i] = 0; m_mode[i] = 0; m_pend[i] = 0;
            m_prev[i] = 0; m_h0[i] = 0; m_h1[i] = 0;
        end
        reset = 1; RDY = 1; CECG_n = 0; irq_n = '1;
        set_bus(0, 0, 2'd0, 8'h00);
        @(posedge clk);
        model_update();
        #1;
        cycle();
        reset = 0;
        cycle();

        // Level request on channel 0 appears with no delay.
        irq_n = 3'b110;
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("lvl_irq", 8'(irq), 8'h01);
        chk("lvl_any", 8'(irq_any), 8'h01);
        chk("lvl_vec", 8'(irq_vec), 8'h00);
`endif
        cycle();

        // Mask channel 0, next level request wins.
        set_bus(1, 0, 2'd0, 8'h01);
        cycle();
        set_bus(0, 1, 2'd0, 8'h00);
        irq_n = 3'b100;
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("mask_irq", 8'(irq), 8'h02);
        chk("mask_vec", 8'(irq_vec), 8'h01);
        chk("rd_dis", dOut, 8'h01);
`endif
        cycle();

        // Edge mode on channel 2: pulse, hold, W1C.
        irq_n = 3'b111;
        set_bus(1, 0, 2'd1, 8'h04);
        cycle();
        set_bus(0, 0, 2'd0, 8'h00);
        irq_n = 3'b011;
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("edge_pre", 8'(irq), 8'h00);
`endif
        cycle();
        irq_n = 3'b111;
        set_bus(0, 1, 2'd2, 8'h00);
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("edge_held", 8'(irq), 8'h04);
        chk("rd_pend", dOut, 8'h04);
`endif
        cycle();
        set_bus(1, 0, 2'd2, 8'h04);
        cycle();
        set_bus(0, 0, 2'd0, 8'h00);
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("w1c_irq", 8'(irq), 8'h00);
`endif
        cycle();

        // Edge and clear in the same cycle: set wins.
        irq_n = 3'b011;
        set_bus(1, 0, 2'd2, 8'h04);
        cycle();
        set_bus(0, 1, 2'd2, 8'h00);
        #1;
`ifndef INT_CTRL_SYNC_EN
        chk("setwin_pend", dOut, 8'h04);
        chk("setwin_irq", 8'(irq), 8'h04);
`endif
        cycle();

        // Write ignored without RDY; reset dominates a write.
        RDY = 0;
        set_bus(1, 0, 2'd1, 8'h00);
        cycle();
        RDY = 1;
        set_bus(0, 1, 2'd1, 8'h00);
        #1;
        chk("rdy0_mode", dOut, 8'h04);
        cycle();
        reset = 1;
        set_bus(1, 0, 2'd0, 8'h07);
        cycle();
        reset = 0;
        set_bus(0, 1, 2'd0, 8'h00);
        #1;
        chk("rst_dis", dOut, 8'h00);
        addr = 2'd1;
        #1;
        chk("rst_mode", dOut, 8'h00);
        addr = 2'd2;
        #1;
        chk("rst_pend", dOut, 8'h00);
        cycle();

`ifdef INT_CTRL_SYNC_EN
        // Synchronised edge channel: irq rises three cycles after irq_n falls.
        irq_n = 3'b111;
        set_bus(1, 0, 2'd1, 8'h01);
        cycle();
        set_bus(0, 0, 2'd0, 8'h00);
        cycle();
        cycle();
        cycle();
        irq_n = 3'b110;
        #1;
        chk("sync_c0", 8'(irq[0]), 8'h00);
        cycle();
        chk("sync_c1", 8'(irq[0]), 8'h00);
        cycle();
        chk("sync_c2", 8'(irq[0]), 8'h00);
        cycle();
        chk("sync_c3", 8'(irq[0]), 8'h01);
`endif

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset  = ($urandom_range(0, 39) == 0);
            RDY    = ($urandom_range(0, 3) != 0);
            CECG_n = ($urandom_range(0, 3) == 0);
            set_bus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 1) == 1) irq_n = irq_n ^ N'(1 << $urandom_range(0, N - 1));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
